key_debounce: RTL

//  - Conditions the raw DE1-SoC KEY[] pushbuttons before they reach the buttons_0 PIO of the soc system.
//  - Per key: 2-FF synchroniser, then a debounce FSM, producing a clean active-high pressed level and 1-cycle press/release strobes.
//  - Sits between the KEY pins and the buttons_0_export input, in the 50 MHz ref-clock domain.

---
 rtl/key_debounce.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Per-key 2-FF synchroniser + debounce FSM with press/release strobes.
// Optional capture/irq logic behind `KEY_DEBOUNCE_IRQ_EN.
module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
`ifdef KEY_DEBOUNCE_IRQ_EN
  ,
  input  logic [NUM_KEYS-1:0] edge_clear,
  output logic [NUM_KEYS-1:0] edge_cap,
  output logic                irq
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] REL_LVL = {NUM_KEYS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_RELEASED,
    S_CONF_PRESS,
    S_PRESSED,
    S_CONF_REL
  } state_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= REL_LVL;
      r_sync2 <= REL_LVL;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // pressed = 1 regardless of pin polarity
  assign w_p = r_sync2 ^ REL_LVL;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          w_acc_p;
    logic          w_acc_r;
    logic          r_level;
    logic          r_press;
    logic          r_rel;

    always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_acc_p    = 1'b0;
      w_acc_r    = 1'b0;
      unique case (r_state)
        S_RELEASED: begin
          if (w_p[g]) begin
            w_state_nx = S_CONF_PRESS;
            w_cnt_nx   = C_ONE;
          end else begin
            w_cnt_nx   = '0;
          end
        end
        S_CONF_PRESS: begin
          if (!w_p[g]) begin
            w_state_nx = S_RELEASED;
            w_cnt_nx   = '0;
          end else if (r_cnt == C_LAST) begin
            w_state_nx = S_PRESSED;
            w_cnt_nx   = '0;
            w_acc_p    = 1'b1;
          end else begin
            w_cnt_nx   = r_cnt + C_ONE;
          end
        end
        S_PRESSED: begin
          if (!w_p[g]) begin
            w_state_nx = S_CONF_REL;
            w_cnt_nx   = C_ONE;
          end else begin
            w_cnt_nx   = '0;
          end
        end
        S_CONF_REL: begin
          if (w_p[g]) begin
            w_state_nx = S_PRESSED;
            w_cnt_nx   = '0;
          end else if (r_cnt == C_LAST) begin
            w_state_nx = S_RELEASED;
            w_cnt_nx   = '0;
            w_acc_r    = 1'b1;
          end else begin
            w_cnt_nx   = r_cnt + C_ONE;
          end
        end
        default: begin
          w_state_nx = S_RELEASED;
          w_cnt_nx   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= S_RELEASED;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_state <= w_state_nx;
        r_cnt   <= w_cnt_nx;
        r_press <= w_acc_p;
        r_rel   <= w_acc_r;
        if (w_acc_p) r_level <= 1'b1;
        else if (w_acc_r) r_level <= 1'b0;
      end
    end

    assign key_level[g]   = r_level;
    assign key_press[g]   = r_press;
    assign key_release[g] = r_rel;
  end

`ifdef KEY_DEBOUNCE_IRQ_EN
  logic [NUM_KEYS-1:0] r_cap;
  logic [NUM_KEYS-1:0] w_cap_nx;
  logic                r_irq;

  // a new press outranks a clear landing in the same cycle
  assign w_cap_nx = (r_cap & ~edge_clear) | key_press;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap <= '0;
      r_irq <= 1'b0;
    end else begin
      r_cap <= w_cap_nx;
      r_irq <= |w_cap_nx;
    end
  end

  assign edge_cap = r_cap;
  assign irq      = r_irq;
`endif

endmodule
